// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, word size
// and the byte-address legality check used when MAR is latched.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'd0,
        MEM_RD_WAIT = 2'd1,
        MEM_WR_WAIT = 2'd2
    } mem_state_e;

    localparam int WORD_BYTES = 4;

    // Word aligned and no address bits set above the RAM's byte range.
    function automatic logic addr_legal(input logic [31:0] addr, input int addr_w);
        logic [31:0] hi_bits;
        hi_bits = addr >> (addr_w + $clog2(WORD_BYTES));
        return ((addr & 32'(WORD_BYTES - 1)) == 32'd0) && (hi_bits == 32'd0);
    endfunction

endpackage

// File: rtl/data_mem_responder_word_ram.sv
// Single-port word RAM: synchronous write, registered read.
module word_ram #(
    parameter int    ADDR_W    = 10,
    parameter int    DATA_W    = 32,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the array and its read register have no reset; a reset branch would
    // stop the array mapping onto block RAM and clearing it is not wanted anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-access responder: MAR latch, load/store with programmable wait states,
// MDR hand-off to the register-file write mux and address-fault reporting.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int    ADDR_W    = 10,
    parameter int    RD_LAT    = 2,
    parameter int    WR_LAT    = 1,
    parameter string INIT_FILE = ""
) (
    input  logic        mem_clk,
    input  logic        mem_rst,
    input  logic        mar_wr_en,
    input  logic [31:0] addr_in,
    input  logic        mem_wr_en,
    input  logic [31:0] wr_data_in,
    input  logic        mdr_rd_en,
    output logic [31:0] mdr_out,
    output logic        mdr_valid,
    output logic        mem_busy,
    output logic        addr_fault
);

    generate
        if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
            $error("RD_LAT must be in 1..15");
        end
        if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
            $error("WR_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [31:0]       mdr_q, mdr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mdr_valid_q, mdr_valid_d;
    logic              mdr_sel_q, mdr_sel_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;
    logic              ram_wr_en, ram_rd_en;
    logic [31:0]       ram_rd_data;
    logic              addr_ok;

    assign addr_ok = addr_legal(addr_in, ADDR_W);

    // NOTE: every signal gets its default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        mar_d       = mar_q;
        mdr_d       = mdr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        mdr_valid_d = mdr_valid_q;
        mdr_sel_d   = mdr_sel_q;
        fault_d     = fault_q;
        ram_wr_en   = 1'b0;
        ram_rd_en   = 1'b0;

        unique case (state_q)
            MEM_IDLE: begin
                if (mdr_rd_en) begin
                    mdr_valid_d = 1'b0;
                end
                if (mar_wr_en) begin
                    mar_d       = addr_in[ADDR_W+1:2];
                    mdr_valid_d = 1'b0;
                    fault_d     = !addr_ok;
                    if (addr_ok && mem_wr_en) begin
                        wdata_d = wr_data_in;
                        cnt_d   = WR_CNT;
                        state_d = MEM_WR_WAIT;
                    end else if (addr_ok) begin
                        cnt_d   = RD_CNT;
                        state_d = MEM_RD_WAIT;
                    end
                end else if (mem_wr_en && !fault_q) begin
                    wdata_d = wr_data_in;
                    cnt_d   = WR_CNT;
                    state_d = MEM_WR_WAIT;
                end
            end
            MEM_RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    // RAM read register becomes the MDR view at the completing edge.
                    ram_rd_en   = 1'b1;
                    mdr_sel_d   = 1'b1;
                    mdr_valid_d = 1'b1;
                    state_d     = MEM_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MEM_WR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    ram_wr_en = 1'b1;
                    if (mdr_valid_q) begin
                        mdr_d     = wdata_q;
                        mdr_sel_d = 1'b0;
                    end
                    state_d = MEM_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase

        busy_d = (state_d != MEM_IDLE);
    end

    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            state_q     <= MEM_IDLE;
            mar_q       <= '0;
            mdr_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            mdr_valid_q <= 1'b0;
            mdr_sel_q   <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            mdr_q       <= mdr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            mdr_valid_q <= mdr_valid_d;
            mdr_sel_q   <= mdr_sel_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
        end
    end

    word_ram #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (32),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clk    (mem_clk),
        .wr_en  (ram_wr_en),
        .rd_en  (ram_rd_en),
        .addr   (mar_q),
        .wr_data(wdata_q),
        .rd_data(ram_rd_data)
    );

    assign mdr_out    = mdr_sel_q ? ram_rd_data : mdr_q;
    assign mdr_valid  = mdr_valid_q;
    assign mem_busy   = busy_q;
    assign addr_fault = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with ADDR_W=10, RD_LAT=2, WR_LAT=1.
module tb_data_mem_responder;

    localparam int ADDR_W = 10;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic        mem_clk = 1'b0;
    logic        mem_rst;
    logic        mar_wr_en;
    logic [31:0] addr_in;
    logic        mem_wr_en;
    logic [31:0] wr_data_in;
    logic        mdr_rd_en;
    logic [31:0] mdr_out;
    logic        mdr_valid;
    logic        mem_busy;
    logic        addr_fault;

    int n_checks = 0;
    int n_fail = 0;
    int proto_errs = 0;

    data_mem_responder #(
        .ADDR_W   (ADDR_W),
        .RD_LAT   (RD_LAT),
        .WR_LAT   (WR_LAT),
        .INIT_FILE("")
    ) dut (
        .mem_clk   (mem_clk),
        .mem_rst   (mem_rst),
        .mar_wr_en (mar_wr_en),
        .addr_in   (addr_in),
        .mem_wr_en (mem_wr_en),
        .wr_data_in(wr_data_in),
        .mdr_rd_en (mdr_rd_en),
        .mdr_out   (mdr_out),
        .mdr_valid (mdr_valid),
        .mem_busy  (mem_busy),
        .addr_fault(addr_fault)
    );

    always #5 mem_clk = ~mem_clk;

    // Requester protocol monitor: any strobe while busy is a requester error.
    always @(posedge mem_clk) begin
        if (!mem_rst && mem_busy && (mar_wr_en || mem_wr_en || mdr_rd_en)) begin
            proto_errs++;
        end
    end

    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic idle_inputs();
        mar_wr_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mdr_rd_en  = 1'b0;
        addr_in    = 32'd0;
        wr_data_in = 32'd0;
    endtask

    // Read: strobe at edge N, result visible after edge N+RD_LAT.
    task automatic do_read(input logic [31:0] a);
        mar_wr_en = 1'b1;
        addr_in   = a;
        step();
        idle_inputs();
        repeat (RD_LAT) step();
    endtask

    task automatic do_write(input logic [31:0] d);
        mem_wr_en  = 1'b1;
        wr_data_in = d;
        step();
        idle_inputs();
        repeat (WR_LAT) step();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        mar_wr_en  = 1'b1;
        mem_wr_en  = 1'b1;
        addr_in    = a;
        wr_data_in = d;
        step();
        idle_inputs();
        repeat (WR_LAT) step();
    endtask

    task automatic do_consume();
        mdr_rd_en = 1'b1;
        step();
        mdr_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        mem_rst = 1'b1;
        repeat (2) step();
        mem_rst = 1'b0;
        n_checks++; if (mem_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", mem_busy); end
        n_checks++; if (mdr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", mdr_valid); end
        n_checks++; if (addr_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", addr_fault); end
        n_checks++; if (mdr_out !== 32'h0) begin n_fail++; $display("FAIL reset_mdr: got %h want 00000000", mdr_out); end
    endtask

    task automatic test_reset_mid_read();
        do_store(32'h10, 32'hDEADBEEF);
        mar_wr_en = 1'b1;
        addr_in   = 32'h10;
        step();
        idle_inputs();
        n_checks++; if (mem_busy !== 1'b1) begin n_fail++; $display("FAIL midrd_busy_before: got %b want 1", mem_busy); end
        mem_rst = 1'b1;
        step();
        mem_rst = 1'b0;
        n_checks++; if (mem_busy !== 1'b0) begin n_fail++; $display("FAIL midrd_busy: got %b want 0", mem_busy); end
        n_checks++; if (mdr_valid !== 1'b0) begin n_fail++; $display("FAIL midrd_valid: got %b want 0", mdr_valid); end
        n_checks++; if (addr_fault !== 1'b0) begin n_fail++; $display("FAIL midrd_fault: got %b want 0", addr_fault); end
        n_checks++; if (mdr_out !== 32'h0) begin n_fail++; $display("FAIL midrd_mdr: got %h want 00000000", mdr_out); end
        // A bare store after reset lands at MAR=0.
        do_write(32'h0BADF00D);
        do_read(32'h0);
        n_checks++; if (mdr_out !== 32'h0BADF00D) begin n_fail++; $display("FAIL midrd_mar_zero: got %h want 0badf00d", mdr_out); end
        do_consume();
    endtask

    task automatic test_read_latency();
        mar_wr_en = 1'b1;
        addr_in   = 32'h10;
        step();
        idle_inputs();
        n_checks++; if (mem_busy !== 1'b1 || mdr_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n0: got busy=%b valid=%b want busy=1 valid=0", mem_busy, mdr_valid); end
        step();
        n_checks++; if (mem_busy !== 1'b1 || mdr_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n1: got busy=%b valid=%b want busy=1 valid=0", mem_busy, mdr_valid); end
        step();
        n_checks++; if (mem_busy !== 1'b0 || mdr_valid !== 1'b1) begin n_fail++; $display("FAIL lat_n2: got busy=%b valid=%b want busy=0 valid=1", mem_busy, mdr_valid); end
        n_checks++; if (mdr_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat_data: got %h want deadbeef", mdr_out); end
        do_consume();
        n_checks++; if (mdr_valid !== 1'b0) begin n_fail++; $display("FAIL lat_consume: got %b want 0", mdr_valid); end
        n_checks++; if (mdr_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat_hold: got %h want deadbeef", mdr_out); end
    endtask

    task automatic test_store_load();
        do_read(32'h20);
        do_consume();
        mem_wr_en  = 1'b1;
        wr_data_in = 32'h12345678;
        step();
        idle_inputs();
        n_checks++; if (mem_busy !== 1'b1) begin n_fail++; $display("FAIL st_busy: got %b want 1", mem_busy); end
        step();
        n_checks++; if (mem_busy !== 1'b0) begin n_fail++; $display("FAIL st_done: got %b want 0", mem_busy); end
        do_read(32'h20);
        n_checks++; if (mdr_out !== 32'h12345678 || mdr_valid !== 1'b1) begin n_fail++; $display("FAIL st_load: got %h/%b want 12345678/1", mdr_out, mdr_valid); end
        do_consume();
    endtask

    task automatic test_fault();
        mar_wr_en = 1'b1;
        addr_in   = 32'h22;
        step();
        idle_inputs();
        n_checks++; if (addr_fault !== 1'b1 || mem_busy !== 1'b0) begin n_fail++; $display("FAIL flt_misalign: got fault=%b busy=%b want 1/0", addr_fault, mem_busy); end
        mem_wr_en  = 1'b1;
        wr_data_in = 32'hFFFFFFFF;
        step();
        idle_inputs();
        n_checks++; if (addr_fault !== 1'b1 || mem_busy !== 1'b0) begin n_fail++; $display("FAIL flt_drop: got fault=%b busy=%b want 1/0", addr_fault, mem_busy); end
        mar_wr_en = 1'b1;
        addr_in   = 32'h1000;
        step();
        idle_inputs();
        n_checks++; if (addr_fault !== 1'b1 || mem_busy !== 1'b0) begin n_fail++; $display("FAIL flt_range: got fault=%b busy=%b want 1/0", addr_fault, mem_busy); end
        do_read(32'h20);
        n_checks++; if (addr_fault !== 1'b0) begin n_fail++; $display("FAIL flt_clear: got %b want 0", addr_fault); end
        n_checks++; if (mdr_out !== 32'h12345678) begin n_fail++; $display("FAIL flt_ram_kept: got %h want 12345678", mdr_out); end
        do_consume();
    endtask

    task automatic test_simultaneous();
        int errs_before;
        do_store(32'h30, 32'hCAFEF00D);
        do_read(32'h10);
        mar_wr_en  = 1'b1;
        mem_wr_en  = 1'b1;
        addr_in    = 32'h8;
        wr_data_in = 32'hA5A5A5A5;
        step();
        n_checks++; if (mem_busy !== 1'b1 || mdr_valid !== 1'b0) begin n_fail++; $display("FAIL sim_start: got busy=%b valid=%b want 1/0", mem_busy, mdr_valid); end
        // Strobes held into the busy cycle must be ignored.
        errs_before = proto_errs;
        addr_in    = 32'h30;
        wr_data_in = 32'h11111111;
        step();
        idle_inputs();
        n_checks++; if (mem_busy !== 1'b0) begin n_fail++; $display("FAIL sim_ignored_busy: got %b want 0", mem_busy); end
        n_checks++; if (proto_errs !== errs_before + 1) begin n_fail++; $display("FAIL sim_flagged: got %0d want %0d", proto_errs, errs_before + 1); end
        do_read(32'h8);
        n_checks++; if (mdr_out !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sim_ram2: got %h want a5a5a5a5", mdr_out); end
        do_consume();
    endtask

    task automatic test_coherence();
        do_read(32'h30);
        n_checks++; if (mdr_out !== 32'hCAFEF00D || mdr_valid !== 1'b1) begin n_fail++; $display("FAIL coh_read: got %h/%b want cafef00d/1", mdr_out, mdr_valid); end
        mem_wr_en  = 1'b1;
        wr_data_in = 32'h55;
        step();
        idle_inputs();
        n_checks++; if (mem_busy !== 1'b1 || mdr_valid !== 1'b1) begin n_fail++; $display("FAIL coh_busy: got busy=%b valid=%b want 1/1", mem_busy, mdr_valid); end
        step();
        n_checks++; if (mdr_out !== 32'h55 || mdr_valid !== 1'b1) begin n_fail++; $display("FAIL coh_mdr: got %h/%b want 00000055/1", mdr_out, mdr_valid); end
        do_consume();
        do_read(32'h30);
        n_checks++; if (mdr_out !== 32'h55) begin n_fail++; $display("FAIL coh_ram: got %h want 00000055", mdr_out); end
        do_consume();
    endtask

    task automatic test_consume_at_completion();
        mar_wr_en = 1'b1;
        addr_in   = 32'h8;
        step();
        idle_inputs();
        mdr_rd_en = 1'b1;
        repeat (RD_LAT) step();
        mdr_rd_en = 1'b0;
        n_checks++; if (mdr_valid !== 1'b1 || mdr_out !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL cons_win: got %h/%b want a5a5a5a5/1", mdr_out, mdr_valid); end
        do_consume();
        do_consume();
        n_checks++; if (mdr_valid !== 1'b0 || mdr_out !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL cons_noop: got %h/%b want a5a5a5a5/0", mdr_out, mdr_valid); end
    endtask

    initial begin
        mem_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_reset_mid_read();
        test_read_latency();
        test_store_load();
        test_fault();
        test_simultaneous();
        test_coherence();
        test_consume_at_completion();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
